// File: rtl/ptx_110110_pkg.sv
// Shared types and defaults for the 110110 serial pattern transmitter.
package ptx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } ptx_state_t;

    localparam logic [5:0]  PTX_PATTERN_DEF = 6'b110110;
    localparam int unsigned PTX_PAT_W_DEF   = 6;

endpackage

// File: rtl/ptx_110110_dcnt.sv
// Loadable, non-wrapping down-counter with zero/one flags.
module ptx_dcnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         is_zero_c,
    output logic         is_one_c
);

    // Load wins over enable; the count saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign is_zero_c = (cnt == '0);
    assign is_one_c  = (cnt == W'(1));

endmodule

// File: rtl/ptx_110110.sv
// Serial transmitter: sends N frames of PATTERN MSB-first with valid/ready and optional gaps.
module ptx_110110
    import ptx_pkg::*;
#(
    parameter int unsigned            PAT_W   = PTX_PAT_W_DEF,
    parameter logic [PAT_W-1:0]       PATTERN = PAT_W'(PTX_PATTERN_DEF),
    parameter int unsigned            CNT_W   = 8,
    parameter int unsigned            GAP_W   = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [CNT_W-1:0] nframes_i,
    input  logic [GAP_W-1:0] gap_i,
    input  logic             ready_i,
    output logic             data_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             frame_o,
    output logic             done_o
);

    localparam int unsigned BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    ptx_state_t       state, next_state;
    logic [GAP_W-1:0] glat;
    logic             glat_load;

    logic [BW-1:0]    bidx;
    logic             bidx_load, bidx_en, bidx_zero, bidx_one;
    logic [CNT_W-1:0] frem;
    logic             frem_load, frem_en, frem_zero, frem_one;
    logic [GAP_W-1:0] gcnt;
    logic             gcnt_load, gcnt_en, gcnt_zero, gcnt_one;
    logic             frame_d, done_d;
    logic             unused_flags;

    ptx_dcnt #(.W(BW)) u_bidx (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .load      (bidx_load),
        .en        (bidx_en),
        .load_val  (BW'(PAT_W - 1)),
        .cnt       (bidx),
        .is_zero_c (bidx_zero),
        .is_one_c  (bidx_one)
    );

    ptx_dcnt #(.W(CNT_W)) u_frem (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .load      (frem_load),
        .en        (frem_en),
        .load_val  (nframes_i),
        .cnt       (frem),
        .is_zero_c (frem_zero),
        .is_one_c  (frem_one)
    );

    ptx_dcnt #(.W(GAP_W)) u_gcnt (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .load      (gcnt_load),
        .en        (gcnt_en),
        .load_val  (glat),
        .cnt       (gcnt),
        .is_zero_c (gcnt_zero),
        .is_one_c  (gcnt_one)
    );

    assign unused_flags = ^{bidx_one, frem_zero, gcnt_zero, frem, gcnt};

    // Next-state and counter control.
    always_comb begin
        next_state = state;
        bidx_load  = 1'b0;
        bidx_en    = 1'b0;
        frem_load  = 1'b0;
        frem_en    = 1'b0;
        gcnt_load  = 1'b0;
        gcnt_en    = 1'b0;
        glat_load  = 1'b0;
        frame_d    = 1'b0;
        done_d     = 1'b0;
        case (state)
            IDLE: begin
                if (start_i && (nframes_i != '0)) begin
                    next_state = SEND;
                    bidx_load  = 1'b1;
                    frem_load  = 1'b1;
                    glat_load  = 1'b1;
                end
            end
            SEND: begin
                if (ready_i) begin
                    if (!bidx_zero) begin
                        bidx_en = 1'b1;
                    end else begin
                        frame_d = 1'b1;
                        frem_en = 1'b1;
                        if (frem_one) begin
                            next_state = IDLE;
                            done_d     = 1'b1;
                        end else if (glat == '0) begin
                            bidx_load = 1'b1;
                        end else begin
                            gcnt_load  = 1'b1;
                            next_state = GAP;
                        end
                    end
                end
            end
            GAP: begin
                gcnt_en = 1'b1;
                if (gcnt_one) begin
                    bidx_load  = 1'b1;
                    next_state = SEND;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State and registered outputs, all derived from the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            glat    <= '0;
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
            frame_o <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            state   <= next_state;
            if (glat_load) begin
                glat <= gap_i;
            end
            valid_o <= (next_state == SEND);
            busy_o  <= (next_state != IDLE);
            frame_o <= frame_d;
            done_o  <= done_d;
        end
    end

    assign data_o = (state == SEND) ? PATTERN[bidx] : 1'b0;

endmodule

// File: tb/tb_ptx_110110.sv
// Table-driven bench for ptx_110110 with hand sequences for reset abort.
module tb_ptx_110110;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       start_i;
    logic [7:0] nframes_i;
    logic [3:0] gap_i;
    logic       ready_i;
    logic       data_o, valid_o, busy_o, frame_o, done_o;

    ptx_110110 dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .start_i   (start_i),
        .nframes_i (nframes_i),
        .gap_i     (gap_i),
        .ready_i   (ready_i),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .busy_o    (busy_o),
        .frame_o   (frame_o),
        .done_o    (done_o)
    );

    always #5 clk = ~clk;

    // exp packs {data, valid, busy, frame, done}
    typedef struct {
        string      tag;
        logic       s;
        logic [7:0] n;
        logic [3:0] g;
        logic       r;
        logic [4:0] exp;
    } vec_t;

    vec_t       vecs[$];
    int         checks = 0;
    int         errors = 0;
    logic [5:0] pat = 6'b110110;

    task automatic add(input string tag, input logic s, input logic [7:0] n,
                       input logic [3:0] g, input logic r, input logic [4:0] exp);
        vec_t v;
        v.tag = tag; v.s = s; v.n = n; v.g = g; v.r = r; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got d/v/b/f/dn=%b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [4:0] outs();
        return {data_o, valid_o, busy_o, frame_o, done_o};
    endfunction

    task automatic run_table();
        foreach (vecs[i]) begin
            @(negedge clk);
            start_i   = vecs[i].s;
            nframes_i = vecs[i].n;
            gap_i     = vecs[i].g;
            ready_i   = vecs[i].r;
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d]", vecs[i].tag, i), outs(), vecs[i].exp);
        end
        vecs.delete();
    endtask

    task automatic add_idle(input string tag, input int k);
        for (int i = 0; i < k; i++) add(tag, 1'b0, 8'd0, 4'd0, 1'b1, 5'b00000);
    endtask

    // One unstalled single frame, start in the first row.
    task automatic add_single(input string tag);
        add(tag, 1'b1, 8'd1, 4'd0, 1'b1, {pat[5], 4'b1100});
        for (int j = 1; j < 6; j++) add(tag, 1'b0, 8'd0, 4'd0, 1'b1, {pat[5-j], 4'b1100});
        add(tag, 1'b0, 8'd0, 4'd0, 1'b1, 5'b00011);
    endtask

    initial begin
        rst_ni = 1'b0; start_i = 1'b0; nframes_i = '0; gap_i = '0; ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("reset_state", outs(), 5'b00000);
        @(negedge clk) rst_ni = 1'b1;

        add_idle("idle", 2);
        add_single("single");
        // restart accepted in the cycle done_o is high
        add_single("restart");
        add_idle("idle", 1);

        add("nf0", 1'b1, 8'd0, 4'd2, 1'b1, 5'b00000);
        add_idle("nf0", 2);

        // three frames back-to-back, with an ignored start mid-sequence
        for (int i = 0; i < 18; i++)
            add("b2b", (i == 0) || (i == 8), (i == 0) ? 8'd3 : 8'd1, (i == 0) ? 4'd0 : 4'd5,
                1'b1, {pat[5 - (i % 6)], 3'b110, 1'b0} | ((i == 6 || i == 12) ? 5'b00010 : 5'b0));
        add("b2b", 1'b0, 8'd0, 4'd0, 1'b1, 5'b00011);
        add_idle("b2b", 1);

        // two frames, gap of three, ignored start during the gap
        for (int i = 0; i < 6; i++)
            add("gap", i == 0, 8'd2, 4'd3, 1'b1, {pat[5-i], 4'b1100});
        add("gap", 1'b0, 8'd0, 4'd0, 1'b1, 5'b00110);
        add("gap", 1'b1, 8'd1, 4'd0, 1'b1, 5'b00100);
        add("gap", 1'b0, 8'd0, 4'd0, 1'b1, 5'b00100);
        for (int i = 0; i < 6; i++)
            add("gap", 1'b0, 8'd0, 4'd0, 1'b1, {pat[5-i], 4'b1100});
        add("gap", 1'b0, 8'd0, 4'd0, 1'b1, 5'b00011);
        add_idle("gap", 1);

        // backpressure on the third bit for four cycles
        add("bp", 1'b1, 8'd1, 4'd0, 1'b1, 5'b11100);
        add("bp", 1'b0, 8'd0, 4'd0, 1'b1, 5'b11100);
        add("bp", 1'b0, 8'd0, 4'd0, 1'b1, 5'b01100);
        for (int i = 0; i < 4; i++) add("bp", 1'b0, 8'd0, 4'd0, 1'b0, 5'b01100);
        add("bp", 1'b0, 8'd0, 4'd0, 1'b1, 5'b11100);
        add("bp", 1'b0, 8'd0, 4'd0, 1'b1, 5'b11100);
        add("bp", 1'b0, 8'd0, 4'd0, 1'b1, 5'b01100);
        add("bp", 1'b0, 8'd0, 4'd0, 1'b1, 5'b00011);
        add_idle("bp", 1);
        run_table();

        // reset asserted while bit 4 is presented
        add("rst_pre", 1'b1, 8'd2, 4'd0, 1'b1, 5'b11100);
        add("rst_pre", 1'b0, 8'd0, 4'd0, 1'b1, 5'b11100);
        add("rst_pre", 1'b0, 8'd0, 4'd0, 1'b1, 5'b01100);
        add("rst_pre", 1'b0, 8'd0, 4'd0, 1'b1, 5'b11100);
        run_table();
        #2 rst_ni = 1'b0;
        #1 check("rst_async", outs(), 5'b00000);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 check($sformatf("rst_hold[%0d]", i), outs(), 5'b00000);
        end
        @(negedge clk) rst_ni = 1'b1;
        add_idle("post_rst", 2);
        add_single("post_rst");
        add_idle("post_rst", 2);
        run_table();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
